// File: rtl/mimo_rr_arbiter.sv
// mimo_rr_arbiter
//   Round-robin arbiter that merges NUM_CH valid/ready input channels into a
//   single registered output stream. Each grant carries at most BURST beats.
//   The grant ends early when the granted channel drops valid. One
//   arbitration (idle) cycle separates consecutive grants.
//
// Parameters
//   WIDTH   data bits per beat (>= 1)
//   NUM_CH  number of input channels (power of two, 2..16)
//   BURST   maximum beats per grant (1..256)
//
// Ports
//   i_clock       clock, rising edge
//   i_reset_n     synchronous active-low reset
//   i_in_data     channel k data in bits [k*WIDTH +: WIDTH]
//   i_in_valid    per-channel valid
//   o_in_ready    per-channel ready (one-hot or zero)
//   o_out_data    registered output beat
//   o_out_valid   registered output valid
//   i_out_ready   downstream ready
//   o_out_chan    source channel of o_out_data (only with MIMO_ARB_CHAN_TAG_EN)
//
// Build option
//   MIMO_ARB_CHAN_TAG_EN  adds the o_out_chan port and its register.

module mimo_rr_arbiter #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 8,
    parameter int BURST  = 4
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic [NUM_CH*WIDTH-1:0]   i_in_data,
    input  logic [NUM_CH-1:0]         i_in_valid,
    output logic [NUM_CH-1:0]         o_in_ready,
    output logic [WIDTH-1:0]          o_out_data,
    output logic                      o_out_valid,
    input  logic                      i_out_ready
`ifdef MIMO_ARB_CHAN_TAG_EN
    ,
    output logic [$clog2(NUM_CH)-1:0] o_out_chan
`endif
);

    localparam int CW  = $clog2(NUM_CH);
    localparam int BCW = $clog2(BURST + 1);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t           state;
    logic [CW-1:0]    cur_ch;
    logic [CW-1:0]    last_grant;
    logic [BCW-1:0]   beat_cnt;

    logic             pipe_ready;
    logic             in_fire;
    logic             out_fire;
    logic             any_valid;
    logic [CW-1:0]    next_ch;
    logic [WIDTH-1:0] sel_data;

    assign pipe_ready = !o_out_valid || i_out_ready;
    assign in_fire    = (state == ST_GRANT) && pipe_ready && i_in_valid[cur_ch];
    assign out_fire   = o_out_valid && i_out_ready;
    assign sel_data   = i_in_data[cur_ch*WIDTH +: WIDTH];

    // Ready is gated by reset so it is zero while reset is asserted, even
    // before the first reset edge has cleared the state.
    always_comb begin
        o_in_ready = '0;
        if (i_reset_n && (state == ST_GRANT) && pipe_ready)
            o_in_ready[cur_ch] = 1'b1;
    end

    // Round-robin search: walk offsets from farthest (last_grant itself) to
    // nearest (last_grant+1) so the nearest valid channel is assigned last
    // and wins. The CW-bit add wraps modulo NUM_CH.
    always_comb begin
        logic [CW-1:0] idx;
        idx       = '0;
        next_ch   = '0;
        any_valid = 1'b0;
        for (int unsigned i = NUM_CH; i >= 1; i--) begin
            idx = last_grant + CW'(i);
            if (i_in_valid[idx]) begin
                next_ch   = idx;
                any_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state       <= ST_IDLE;
            cur_ch      <= '0;
            last_grant  <= CW'(NUM_CH - 1);
            beat_cnt    <= '0;
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
`ifdef MIMO_ARB_CHAN_TAG_EN
            o_out_chan  <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        cur_ch     <= next_ch;
                        last_grant <= next_ch;
                        beat_cnt   <= '0;
                        state      <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // A stalled pipe freezes the grant, even if valid drops,
                    // so no beat is lost or duplicated.
                    if (pipe_ready) begin
                        if (i_in_valid[cur_ch]) begin
                            beat_cnt <= beat_cnt + BCW'(1);
                            if (beat_cnt == BCW'(BURST - 1))
                                state <= ST_IDLE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (in_fire) begin
                o_out_data  <= sel_data;
                o_out_valid <= 1'b1;
`ifdef MIMO_ARB_CHAN_TAG_EN
                o_out_chan  <= cur_ch;
`endif
            end else if (out_fire) begin
                o_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mimo_rr_arbiter.md
MIMO_RR_ARBITER -- requirements
Module: mimo_rr_arbiter

Interface
REQ-001 Parameter WIDTH, 8: data bits per channel beat; SHALL be >= 1.
REQ-002 Parameter NUM_CH, 8: number of input channels; SHALL be a power of two, 2..16.
REQ-003 Parameter BURST, 4: maximum beats per grant; SHALL be 1..256.
REQ-004 Port i_clock  in  1: single clock; all state SHALL update on its rising edge.
REQ-005 Port i_reset_n  in  1: reset, synchronous and active-low.
REQ-006 Port i_in_data  in  NUM_CH*WIDTH: channel k data in bits [k*WIDTH +: WIDTH].
REQ-007 Port i_in_valid  in  NUM_CH: per-channel valid.
REQ-008 Port o_in_ready  out  NUM_CH: per-channel ready; SHALL be one-hot or zero.
REQ-009 Port o_out_data  out  WIDTH: registered output beat feeding the downstream FIFO.
REQ-010 Port o_out_valid  out  1: registered output valid.
REQ-011 Port i_out_ready  in  1: downstream ready (FIFO o_in_ready).
REQ-012 Port o_out_chan  out  $clog2(NUM_CH): source channel of o_out_data; present only per REQ-030.

Function
REQ-013 A beat SHALL transfer on any interface in a cycle where valid and ready are both 1.
REQ-014 Pipe-ready SHALL be defined as (!o_out_valid || i_out_ready).
REQ-015 The state machine SHALL have exactly two states, ST_IDLE and ST_GRANT.
REQ-016 In ST_IDLE, o_in_ready SHALL be all zeros.
REQ-017 In ST_IDLE with any i_in_valid bit set, the block SHALL select the first valid channel searching upward from (last_grant+1) mod NUM_CH and wrapping.
REQ-018 On that selection, the block SHALL store the selected channel in cur_ch, store it in last_grant, clear beat_cnt, and enter ST_GRANT on the next cycle.
REQ-019 In ST_GRANT, o_in_ready[cur_ch] SHALL equal pipe-ready, and all other ready bits SHALL be 0.
REQ-020 On each accepted input beat, the block SHALL load o_out_data with the channel's data, set o_out_valid to 1, and increment beat_cnt; latency SHALL be one cycle from input to output.
REQ-021 When an output beat is accepted and no input beat is accepted in the same cycle, o_out_valid SHALL go to 0.
REQ-022 ST_GRANT SHALL return to ST_IDLE after the accepted beat that makes beat_cnt equal BURST.
REQ-023 ST_GRANT SHALL also return to ST_IDLE in any cycle where i_in_valid[cur_ch] is 0; there is exactly one idle (arbitration) cycle between grants.
REQ-024 With pipe-ready at 0, the block SHALL hold its state, beat_cnt and output register unchanged; it SHALL NOT drop or duplicate beats.
REQ-025 Simultaneous output accept and new input accept SHALL replace the output register with no bubble.
REQ-026 beat_cnt SHALL be $clog2(BURST+1) bits wide and SHALL never wrap.

Reset
REQ-027 While i_reset_n is 0 at a clock edge, the block SHALL set state to ST_IDLE, o_out_valid to 0, o_out_data to 0, o_out_chan to 0, cur_ch to 0, beat_cnt to 0, and last_grant to NUM_CH-1, so channel 0 wins first.
REQ-028 During reset, o_in_ready SHALL be all zeros.
REQ-029 Reset mid-burst SHALL discard any held output beat, and the next arbitration SHALL restart from channel 0.

Configuration
REQ-030 With macro MIMO_ARB_CHAN_TAG_EN defined, port o_out_chan SHALL exist and SHALL be registered alongside o_out_data with value cur_ch.
REQ-031 Without MIMO_ARB_CHAN_TAG_EN, port o_out_chan and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 After reset, drive all 8 valid bits high with i_out_ready=1 and BURST=4 -> output SHALL be 4 beats from ch0, 1 bubble, 4 beats from ch1, and so on through ch7, then ch0 again.
REQ-033 Drive ch3 only, holding valid for 2 beats then dropping it -> output SHALL be 2 beats tagged 3, and the arbiter SHALL return to ST_IDLE with no further ready on ch3.
REQ-034 Hold i_out_ready=0 for 5 cycles mid-burst with data 0xA5 held -> o_out_data SHALL stay 0xA5 and o_out_valid SHALL stay 1; all ready bits SHALL be 0; no beat SHALL be lost once ready returns.
REQ-035 With ch5 and ch6 valid and last_grant=5 -> ch6 SHALL be granted next, then ch5 after ch6's burst.
REQ-036 Assert i_reset_n=0 for 1 cycle after 2 beats of a ch2 burst -> o_out_valid SHALL be 0 on the next cycle, and the next grant SHALL go to ch0 if ch0 is valid.
REQ-037 Build with and without MIMO_ARB_CHAN_TAG_EN and run REQ-032 -> the data streams SHALL be identical, and the tag SHALL match the source channel on every beat.
